fetch_imem: RTL
===============

FETCH_IMEM -- requirements
Module: fetch_imem

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction words, power of two, 4..4096.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning cycles from request acceptance to response availability, 1..4.
REQ-003 SHALL have parameter ADDR_W, default 64, meaning byte-address width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: CLK input 1, rising-edge clock; Reset_L input 1, asynchronous active-low reset.
REQ-005 SHALL have port ReqValid input 1, meaning a fetch request is offered.
REQ-006 SHALL have port ReqReady output 1, meaning a fetch request can be accepted.
REQ-007 SHALL have port Address input ADDR_W, meaning the fetch byte address.
REQ-008 SHALL have port RspValid output 1, meaning a response is presented.
REQ-009 SHALL have port RspReady input 1, meaning the consumer takes the response.
REQ-010 SHALL have port Data output 32, meaning the fetched instruction.
REQ-011 SHALL have port Fault output 2, with encoding 00 ok, 01 misaligned, 10 out-of-range.
REQ-012 SHALL have port LoadEn input 1, meaning program-load write strobe.
REQ-013 SHALL have port LoadAddr input log2(DEPTH), meaning program-load word index.
REQ-014 SHALL have port LoadData input 32, meaning program-load word.

Function
REQ-015 SHALL accept a request on a rising CLK edge with ReqValid and ReqReady both high.
REQ-016 SHALL make the response for an accepted request eligible for RspValid exactly RD_LAT cycles after acceptance, given an empty response FIFO and RspReady high.
REQ-017 SHALL deliver responses strictly in acceptance order, with no loss or duplication.
REQ-018 SHALL contain a response FIFO of depth RD_LAT+1; ReqReady = !LoadEn && (in-flight + FIFO occupancy) < RD_LAT+1.
REQ-019 SHALL pop a response on a rising edge with RspValid and RspReady both high; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-020 SHALL hold Data and Fault stable while RspValid is high and RspReady is low.
REQ-021 SHALL report Fault=01 and Data=0 when Address[1:0] != 0; misaligned takes priority over out-of-range.
REQ-022 SHALL report Fault=10 and Data=0 when Address[ADDR_W-1:2] >= DEPTH.
REQ-023 SHALL otherwise return the word at index Address[log2(DEPTH)+1:2] with Fault=00.
REQ-024 SHALL write LoadData to word LoadAddr on a rising edge with LoadEn high.
REQ-025 SHALL block new requests via ReqReady while LoadEn is high; in-flight responses SHALL still drain.
REQ-026 SHALL return the loaded value for a request accepted on the cycle after the load edge or later.
REQ-027 SHALL sample the array for in-flight requests at acceptance, so a later load does not alter their response.
REQ-028 SHALL return 0 for a never-written word in simulation; X is not permitted on Data.

Reset
REQ-029 SHALL, while Reset_L is low, force RspValid=0, ReqReady=0, Data=0 and Fault=00, with in-flight count and FIFO pointers at 0.
REQ-030 SHALL, when reset is asserted mid-operation, discard all in-flight and buffered responses; array contents SHALL be retained.
REQ-031 SHALL deassert ReqReady for the first edge after Reset_L rises and may assert it from the next cycle.

Structure
REQ-032 SHALL place Fault encodings (FAULT_OK, FAULT_MISALIGN, FAULT_RANGE) and the NOP/zero constant in shared package imem_pkg.
REQ-033 SHALL implement the response FIFO as sub-module imem_rsp_fifo, parametrised by width 34 and depth RD_LAT+1.
REQ-034 SHALL implement the read pipeline as an RD_LAT-stage valid/data shift register inside fetch_imem.

Verification
REQ-035 SHALL cover: with RD_LAT=2, load 0xF84003E9 at index 0, then fetch 0x000 -> RspValid 2 cycles after acceptance, Data=0xF84003E9, Fault=00.
REQ-036 SHALL cover: fetch 0x006 -> Data=0, Fault=01; fetch 0x100 with DEPTH=64 -> Data=0, Fault=10; fetch 0x0FC -> word 63, Fault=00.
REQ-037 SHALL cover: with RD_LAT=2 and RspReady=0, offer 5 back-to-back requests 0x000..0x010 -> exactly 3 accepted, ReqReady low; after RspReady=1 -> 3 responses in order, then the rest.
REQ-038 SHALL cover: LoadEn pulse at index 1 with 0x8B0901AD while a fetch of 0x004 is in flight -> in-flight returns the old word; next fetch returns 0x8B0901AD; ReqReady low during LoadEn.
REQ-039 SHALL cover: assert Reset_L=0 with 2 responses buffered -> RspValid=0 immediately (async); after release, refetch of 0x000 returns the pre-reset loaded value.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch block: fault codes,
// the zero/NOP word and the packed response record carried through the
// read pipeline and response FIFO.
package imem_pkg;

    // Fault code returned alongside every fetch response.
    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    // Word returned on faults, when idle, and for never-written locations.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // One response: fault code in the top two bits, instruction word below.
    localparam int RSP_W = 34;

    typedef struct packed {
        fault_e      fault;
        logic [31:0] data;
    } rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous FIFO holding completed fetch responses until the
// consumer takes them. Depth need not be a power of two; pointers wrap
// explicitly. Head entry is presented combinationally on data_o.
module imem_rsp_fifo #(
    parameter int  WIDTH = 34,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign data_o  = store_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on push.
    // NOTE: storage arrays carry no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_imem.sv
// Instruction memory with a valid/ready fetch port. A request is classified
// (misaligned / out-of-range / ok) and the array sampled at acceptance, then
// carried through an RD_LAT-stage shift register into a response FIFO of
// depth RD_LAT+1. Credits (pipeline + FIFO occupancy) gate ReqReady so the
// pipeline never has to stall. A separate load port writes program words.
module fetch_imem
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 64
) (
    input  logic                     CLK,
    input  logic                     Reset_L,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [ADDR_W-1:0]        Address,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [31:0]              Data,
    output logic [1:0]               Fault,
    input  logic                     LoadEn,
    input  logic [$clog2(DEPTH)-1:0] LoadAddr,
    input  logic [31:0]              LoadData
);

    localparam int IDX_W      = $clog2(DEPTH);
    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // Two-state storage so never-written words read as zero in simulation.
    bit   [31:0]       mem_q [DEPTH];

    logic [RD_LAT-1:0] pipe_vld_q;
    rsp_t              pipe_rsp_q [RD_LAT];

    logic              ready_en_q;
    logic              req_fire;
    logic              rsp_pop;
    logic [IDX_W-1:0]  rd_idx;
    logic              out_of_range;
    rsp_t              req_rsp;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic              fifo_valid;
    logic [RSP_W-1:0]  fifo_head_bits;
    rsp_t              fifo_head;

    assign rd_idx       = Address[IDX_W+1:2];
    assign out_of_range = (Address[ADDR_W-1:2] >= (ADDR_W - 2)'(DEPTH));
    assign occupancy    = inflight + fifo_count;
    assign ReqReady     = ready_en_q && !LoadEn && (occupancy < CNT_W'(FIFO_DEPTH));
    assign req_fire     = ReqValid && ReqReady;
    assign rsp_pop      = RspValid && RspReady;
    assign fifo_head    = rsp_t'(fifo_head_bits);

    // Program-load port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (LoadEn) begin
            mem_q[LoadAddr] <= LoadData;
        end
    end

    // Classify the offered address and read the array for it.
    always_comb begin
        req_rsp.fault = FAULT_OK;
        req_rsp.data  = mem_q[rd_idx];
        if (Address[1:0] != 2'b00) begin
            req_rsp.fault = FAULT_MISALIGN;
            req_rsp.data  = NOP_WORD;
        end else if (out_of_range) begin
            req_rsp.fault = FAULT_RANGE;
            req_rsp.data  = NOP_WORD;
        end
    end

    // Hold ReqReady low for the first edge after reset release.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Valid bits of the read pipeline; reset discards in-flight requests.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= req_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Payload of the read pipeline, captured at acceptance and shifted along.
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            pipe_rsp_q[0] <= req_rsp;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_rsp_q[i] <= pipe_rsp_q[i-1];
        end
    end

    // Count requests still travelling through the pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    imem_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_n_i     (Reset_L),
        .push_i      (pipe_vld_q[RD_LAT-1]),
        .push_data_i (pipe_rsp_q[RD_LAT-1]),
        .pop_i       (rsp_pop),
        .valid_o     (fifo_valid),
        .data_o      (fifo_head_bits),
        .count_o     (fifo_count)
    );

    // Present the FIFO head; drive zeros whenever nothing is presented.
    always_comb begin
        RspValid = fifo_valid;
        Data     = NOP_WORD;
        Fault    = FAULT_OK;
        if (fifo_valid) begin
            Data  = fifo_head.data;
            Fault = fifo_head.fault;
        end
    end

endmodule
